led_seq: RTL
============

# led_seq

Parametrised LED sequencer, the successor to the fixed 4-LED, 4-second walking-light block. It drives N active-low board LEDs from a step timer derived from the 50 MHz board clock. It supports four run-time patterns: walk left, walk right, bounce and blink-all. It also provides pause and a 4-level speed select, and sits directly between the top-level clock/reset pins and the LED pins.

## Interface
- `N_LED`, 4, number of LEDs driven; must be ≥ 1.
- `STEP_CYCLES`, 50_000_000, clock cycles per step at speed 0 (1 s at 50 MHz); must be ≥ 8.
- `CNT_W`, 32, step timer width; must satisfy 2^CNT_W > STEP_CYCLES.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  1 = timer runs; 0 = pause (timer and pattern held).
- `mode`  in  2  00 walk-left, 01 walk-right, 10 bounce, 11 blink-all.
- `speed`  in  2  step period = `STEP_CYCLES >> speed` (1×, 2×, 4×, 8× faster).
- `led`  out  N_LED  active-low LED drive (0 = lit).
- `step_pulse`  out  1  one-cycle strobe, high in the cycle `led` takes a new value.

## Operation
- State machine with two states:
  - IDLE: entered on reset; all LEDs off.
  - RUN: entered on the first step.
- Step timer `timer` (CNT_W bits):
  - Increments each cycle while `en`=1 and holds while `en`=0.
  - A step fires when `en`=1 and `timer >= period-1`, where `period = STEP_CYCLES >> speed`. On a step, `timer` returns to 0.
  - Using `>=` means a speed change that shrinks the period below the current count fires a step on the next enabled cycle. The timer never wraps through 2^CNT_W.
- Position register `pos` (0..N_LED-1), direction flag `dir` (0 = up) and blink phase `ph`. All are updated only on a step.
- First step out of IDLE:
  - modes 00/10: `pos`=0, `dir`=0.
  - mode 01: `pos`=N_LED-1.
  - mode 11: `ph`=1.
- Subsequent steps, by mode:
  - 00: `pos` = pos+1, wrapping N_LED-1 → 0.
  - 01: `pos` = pos-1, wrapping 0 → N_LED-1.
  - 10: `pos` moves in direction `dir`. At `pos`=N_LED-1 going up, `dir` becomes 1 and `pos`=N_LED-2. At `pos`=0 going down, `dir` becomes 0 and `pos`=1. Endpoints are never repeated. With N_LED=1, `pos` stays 0.
  - 11: `ph` toggles; `pos` is held.
- Output:
  - modes 00/01/10: `led` = all ones except bit `pos` = 0.
  - mode 11: `led` = all zeros when `ph`=1, all ones when `ph`=0.
- Mode changes are sampled only on a step. The new mode applies to that step using the current `pos`. Entering 11 sets `ph`=1. Leaving 11 for 10 keeps `dir`.

## Timing
- Reset, sampled on a `clk` edge with `rst_n`=0, sets: `led`=all ones, `step_pulse`=0, `timer`=0, `pos`=0, `dir`=0, `ph`=0, state IDLE.
  - `rst_n` low between edges has no effect.
  - Reset mid-run aborts the current step with no partial update.
- With `en`=1 and fixed `speed` from reset release, the first `led` change lands on the edge ending the `period`-th enabled cycle. Later changes follow every `period` enabled cycles.
- `led` and `step_pulse` are registered outputs with no combinational path from the inputs.
- Simultaneous events:
  - `en` falling in the cycle `timer`=period-1: no step fires.
  - `speed` and `mode` changing together: both take effect on the same step.

## Configuration
- `LED_SEQ_BOUNCE_EN`:
  - Defined: mode 10 is bounce as described above.
  - Undefined: the bounce logic and `dir` are not built, and mode 10 behaves exactly as mode 00 (walk-left).

## Test plan
(All with N_LED=4, STEP_CYCLES=8, `speed`=0 unless noted, `LED_SEQ_BOUNCE_EN` defined.)
- Reset with `en`=1, mode 00 → `led`=1111 for 8 cycles, then 1110, 1101, 1011, 0111, 1110 at cycles 8, 16, 24, 32, 40. `step_pulse` is high exactly at those cycles.
- mode 01 from reset → 0111, 1011, 1101, 1110, 0111 on successive steps.
- mode 10 from reset → 1110, 1101, 1011, 0111, 1011, 1101, 1110, 1101. Rebuilt without the macro → walk-left sequence.
- mode 11 → 0000, 1111, 0000. Switching to mode 00 after a blink step resumes at the held `pos`+1.
- Pause and speed change:
  - `en`=0 for 20 cycles at `timer`=3 → the next step is delayed by 20 cycles.
  - `speed`=3 (period 1) → `led` steps every enabled cycle.
  - Changing `speed` 0 → 2 at `timer`=5 → step on the next cycle.
- Reset mid-run: `rst_n`=0 for one edge while `led`=1101 → `led`=1111 and `step_pulse`=0 after that edge. Re-run → first step at 8 cycles shows 1110.

Source files
------------

// File: rtl/led_seq_if.sv
// Control/LED bundle between the board-level controller and the led_seq sequencer.
interface led_seq_if #(
    parameter int N_LED = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [1:0]       speed;
    logic [N_LED-1:0] led;
    logic             step_pulse;

    modport master (output en, mode, speed, input led, step_pulse);
    modport slave  (input en, mode, speed, output led, step_pulse);
endinterface

// File: rtl/led_seq.sv
// Parametrised active-low LED sequencer: walk-left, walk-right, bounce and blink-all.
// Optional feature macro: LED_SEQ_BOUNCE_EN (undefined -> mode 10 acts as walk-left).
module led_seq #(
    parameter int N_LED       = 4,
    parameter int STEP_CYCLES = 50_000_000,
    parameter int CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    led_seq_if.slave     bus_if
);
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam int               POS_W   = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LED - 1);
    localparam logic [N_LED-1:0] ALL_OFF = {N_LED{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             ph_q, ph_d;
    logic [1:0]       mode_q, mode_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] period_s;
    logic             fire_s;
`ifdef LED_SEQ_BOUNCE_EN
    logic             dir_q, dir_d;
`endif

    // Step timer: compare with >= so a shrinking period fires on the next enabled cycle.
    always_comb begin
        period_s = CNT_W'(STEP_CYCLES) >> bus_if.speed;
        fire_s   = bus_if.en && (timer_q >= (period_s - CNT_W'(1)));
        if (fire_s) begin
            timer_d = {CNT_W{1'b0}};
        end else if (bus_if.en) begin
            timer_d = timer_q + CNT_W'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    // Next-state logic for FSM, position, direction and blink phase.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        ph_d    = ph_q;
        mode_d  = mode_q;
`ifdef LED_SEQ_BOUNCE_EN
        dir_d   = dir_q;
`endif
        if (fire_s) begin
            state_d = RUN;
            mode_d  = bus_if.mode;
            if (state_q == IDLE) begin
                case (bus_if.mode)
                    2'b01:   pos_d = POS_MAX;
                    2'b11:   ph_d  = 1'b1;
                    default: begin
                        pos_d = {POS_W{1'b0}};
`ifdef LED_SEQ_BOUNCE_EN
                        dir_d = 1'b0;
`endif
                    end
                endcase
            end else begin
                case (bus_if.mode)
                    2'b00:   pos_d = (pos_q == POS_MAX) ? {POS_W{1'b0}} : pos_q + POS_W'(1);
                    2'b01:   pos_d = (pos_q == {POS_W{1'b0}}) ? POS_MAX : pos_q - POS_W'(1);
                    2'b10: begin
`ifdef LED_SEQ_BOUNCE_EN
                        // Endpoints turn around immediately so they are shown only once.
                        if (N_LED == 1) begin
                            pos_d = {POS_W{1'b0}};
                        end else if (!dir_q) begin
                            if (pos_q == POS_MAX) begin
                                dir_d = 1'b1;
                                pos_d = POS_MAX - POS_W'(1);
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                            end
                        end else begin
                            if (pos_q == {POS_W{1'b0}}) begin
                                dir_d = 1'b0;
                                pos_d = POS_W'(1);
                            end else begin
                                pos_d = pos_q - POS_W'(1);
                            end
                        end
`else
                        pos_d = (pos_q == POS_MAX) ? {POS_W{1'b0}} : pos_q + POS_W'(1);
`endif
                    end
                    2'b11:   ph_d = (mode_q == 2'b11) ? ~ph_q : 1'b1;
                    default: pos_d = pos_q;
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Output next-values; led only changes on a step and is then registered.
    always_comb begin
        pulse_d = fire_s;
        led_d   = led_q;
        if (fire_s) begin
            if (bus_if.mode == 2'b11) begin
                led_d = ph_d ? {N_LED{1'b0}} : ALL_OFF;
            end else begin
                led_d = ~(N_LED'(1'b1) << pos_d);
            end
        end else begin
            led_d = led_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= {CNT_W{1'b0}};
            pos_q   <= {POS_W{1'b0}};
            ph_q    <= 1'b0;
            mode_q  <= 2'b00;
            led_q   <= ALL_OFF;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pos_q   <= pos_d;
            ph_q    <= ph_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
            pulse_q <= pulse_d;
        end
    end

`ifdef LED_SEQ_BOUNCE_EN
    // Bounce direction register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

    assign bus_if.led        = led_q;
    assign bus_if.step_pulse = pulse_q;
endmodule
